// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//   APB3 requester between the RISC-V core data bus and the APB peripherals.
//   It takes one core load/store request at a time and decodes its address
//   into a one-hot PSEL. It then runs the SETUP and ACCESS phases, waits for
//   PREADY from the selected slave, and returns the read data with a
//   one-cycle READY_O pulse. An address outside the APB window, or one that
//   points at a slave that does not exist, completes one cycle later with
//   ERR_O=1 and causes no bus activity.
//
// Optional feature (macro APB_MASTER_TIMEOUT_EN):
//   When the macro is defined, an ACCESS phase that sees no PREADY for
//   TIMEOUT_CYCLES cycles is aborted with ERR_O=1 and RDATA_O=0. When the
//   macro is not defined, ACCESS waits for PREADY with no limit.
//
// Parameters:
//   NUM_SLAVES      number of APB slaves / PSEL lines (1..16)
//   BASE_ADDR       APB window base; only bits [31:16] are compared
//   TIMEOUT_CYCLES  ACCESS cycles without PREADY before abort (macro only)
//
// Ports:
//   PCLK        in   clock
//   PRESET      in   synchronous active-high reset
//   TRANSFER_I  in   core request strobe, held by the core until READY_O
//   ADDR_I      in   [31:0] request byte address
//   WRITE_I     in   1=write, 0=read
//   WDATA_I     in   [31:0] write data
//   RDATA_O     out  [31:0] read data, valid while READY_O=1
//   READY_O     out  one-cycle completion pulse
//   ERR_O       out  error flag, valid while READY_O=1
//   PADDR       out  [31:0] APB address
//   PWDATA      out  [31:0] APB write data
//   PWRITE      out  APB direction
//   PSEL        out  [NUM_SLAVES-1:0] one-hot slave select
//   PENABLE     out  APB access phase
//   PRDATA_ALL  in   [32*NUM_SLAVES-1:0] slave k read data at [32k+31:32k]
//   PREADY_ALL  in   [NUM_SLAVES-1:0] slave k PREADY at bit k
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       TRANSFER_I,
  input  logic [31:0]                ADDR_I,
  input  logic                       WRITE_I,
  input  logic [31:0]                WDATA_I,
  output logic [31:0]                RDATA_O,
  output logic                       READY_O,
  output logic                       ERR_O,
  output logic [31:0]                PADDR,
  output logic [31:0]                PWDATA,
  output logic                       PWRITE,
  output logic [NUM_SLAVES-1:0]      PSEL,
  output logic                       PENABLE,
  input  logic [32*NUM_SLAVES-1:0]   PRDATA_ALL,
  input  logic [NUM_SLAVES-1:0]      PREADY_ALL
);

  // An illegal parameter set stops elaboration instead of building a bad decoder.
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master_bridge: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [31:0]             paddr_q, paddr_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic                    pwrite_q, pwrite_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires in the ACCESS cycle in which the count would reach the limit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic        addr_mapped;
  logic        pready_sel;
  logic [31:0] prdata_sel;

  // Turns a slave index into its one-hot PSEL pattern.
  function automatic logic [NUM_SLAVES-1:0] decode_sel(input logic [3:0] idx);
    logic [NUM_SLAVES-1:0] sel;
    sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx == 4'(k)) sel[k] = 1'b1;
    end
    return sel;
  endfunction

  assign addr_mapped = (ADDR_I[31:16] == BASE_ADDR[31:16]) &&
                       ({28'd0, ADDR_I[15:12]} < 32'(NUM_SLAVES));

  // Only the latched slave's PREADY and PRDATA are seen; other slaves are ignored.
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == 4'(k)) begin
        pready_sel = PREADY_ALL[k];
        prdata_sel = PRDATA_ALL[32*k +: 32];
      end
    end
  end

  // Next-state logic. The bus outputs are registered, so each branch sets
  // the values they must have in the state it is about to enter.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    psel_d    = '0;
    penable_d = 1'b0;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (TRANSFER_I) begin
          if (addr_mapped) begin
            state_d  = ST_SETUP;
            idx_d    = ADDR_I[15:12];
            paddr_d  = ADDR_I;
            pwrite_d = WRITE_I;
            pwdata_d = WDATA_I;
            psel_d   = decode_sel(ADDR_I[15:12]);
          end else begin
            // An unmapped request completes at once and the APB bus stays quiet.
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel_d    = decode_sel(idx_q);
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      ST_ACCESS: begin
        if (pready_sel) begin
          // PREADY wins even in the cycle the timeout limit is reached.
          state_d = ST_RESP;
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = pwrite_q ? 32'd0 : prdata_sel;
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            psel_d    = decode_sel(idx_q);
            penable_d = 1'b1;
          end
`else
          psel_d    = decode_sel(idx_q);
          penable_d = 1'b1;
`endif
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, with a synchronous reset to the idle bus.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign RDATA_O = rdata_q;
  assign READY_O = ready_q;
  assign ERR_O   = err_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed testbench for apb_master_bridge with four slaves. A small slave
// model inside runTransfer drives PREADY after a chosen number of wait
// states. Every transfer is timed from the accepting clock edge, and the
// result, the PSEL/PENABLE behaviour and the stability of the address and
// data are checked against hand-computed values.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

   localparam int NS = 4;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              TRANSFER_I;
   logic [31:0]       ADDR_I;
   logic              WRITE_I;
   logic [31:0]       WDATA_I;
   logic [31:0]       RDATA_O;
   logic              READY_O;
   logic              ERR_O;
   logic [31:0]       PADDR;
   logic [31:0]       PWDATA;
   logic              PWRITE;
   logic [NS-1:0]     PSEL;
   logic              PENABLE;
   logic [32*NS-1:0]  PRDATA_ALL;
   logic [NS-1:0]     PREADY_ALL;

   int passCount  = 0;
   int checkCount = 0;

   apb_master_bridge #(
      .NUM_SLAVES(NS),
      .BASE_ADDR(32'h1000_0000),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .PCLK(PCLK),
      .PRESET(PRESET),
      .TRANSFER_I(TRANSFER_I),
      .ADDR_I(ADDR_I),
      .WRITE_I(WRITE_I),
      .WDATA_I(WDATA_I),
      .RDATA_O(RDATA_O),
      .READY_O(READY_O),
      .ERR_O(ERR_O),
      .PADDR(PADDR),
      .PWDATA(PWDATA),
      .PWRITE(PWRITE),
      .PSEL(PSEL),
      .PENABLE(PENABLE),
      .PRDATA_ALL(PRDATA_ALL),
      .PREADY_ALL(PREADY_ALL)
   );

   // Free-running 10-time-unit clock
   always #5 PCLK = ~PCLK;

   // Counts one comparison and reports it if the two values differ
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
   endtask

   // Places a core request on the inputs; the next rising edge accepts it
   task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
      ADDR_I     = addr;
      WRITE_I    = wr;
      WDATA_I    = wdata;
      TRANSFER_I = 1'b1;
   endtask

   // Runs one request with a slave that adds waitStates wait states, then checks
   // the latency, result, bus protocol and one-cycle READY_O pulse.
   // slave < 0 means no PSEL line is expected to assert.
   task automatic runTransfer(input string tag, input logic [31:0] addr, input logic wr,
                              input logic [31:0] wdata, input int slave, input int waitStates,
                              input logic otherReady, input int expLatency, input int expPen,
                              input logic [31:0] expRdata, input logic expErr);
      logic [NS-1:0] expPsel;
      logic [31:0]   gotRdata;
      logic          gotErr;
      int            latency;
      int            accessCnt;
      int            penCycles;
      int            badCycles;
      expPsel   = (slave >= 0) ? NS'(1 << slave) : '0;
      gotRdata  = '0;
      gotErr    = 1'b0;
      latency   = 0;
      accessCnt = 0;
      penCycles = 0;
      badCycles = 0;
      applyStimulus(addr, wr, wdata);
      for (int k = 0; k < NS; k++) PREADY_ALL[k] = (k == slave) ? 1'b0 : otherReady;
      for (int n = 1; n <= 60 && latency == 0; n++) begin
         @(negedge PCLK);
         if (PSEL != '0) begin
            if (PSEL !== expPsel || PADDR !== addr || PWRITE !== wr || (wr && PWDATA !== wdata))
               badCycles++;
         end
         if (PENABLE && PSEL == '0) badCycles++;
         if (PENABLE) penCycles++;
         if (READY_O) begin
            latency    = n;
            gotRdata   = RDATA_O;
            gotErr     = ERR_O;
            TRANSFER_I = 1'b0;
         end
         for (int k = 0; k < NS; k++) begin
            if (k == slave) begin
               if (PSEL[k] && PENABLE) begin
                  accessCnt++;
                  PREADY_ALL[k] = (accessCnt > waitStates);
               end else begin
                  PREADY_ALL[k] = 1'b0;
               end
            end else begin
               PREADY_ALL[k] = otherReady;
            end
         end
      end
      TRANSFER_I = 1'b0;
      checkOutput({tag, "/latency"}, latency, expLatency);
      checkOutput({tag, "/err"}, {31'd0, gotErr}, {31'd0, expErr});
      checkOutput({tag, "/rdata"}, gotRdata, expRdata);
      checkOutput({tag, "/bus_protocol"}, badCycles, 0);
      checkOutput({tag, "/penable_cycles"}, penCycles, expPen);
      PREADY_ALL = '0;
      @(negedge PCLK);
      checkOutput({tag, "/ready_pulse"}, {31'd0, READY_O}, 32'd0);
   endtask

   // Main directed sequence
   initial begin
      PRESET     = 1'b1;
      TRANSFER_I = 1'b1;
      ADDR_I     = 32'h1000_1000;
      WRITE_I    = 1'b1;
      WDATA_I    = 32'hA5A5_A5A5;
      PREADY_ALL = '0;
      PRDATA_ALL = '0;
      PRDATA_ALL[32*0 +: 32] = 32'hFFFF_FFFF;
      PRDATA_ALL[32*1 +: 32] = 32'hDEAD_BEEF;
      PRDATA_ALL[32*2 +: 32] = 32'h0000_005A;
      PRDATA_ALL[32*3 +: 32] = 32'h1234_5678;

      // Reset held two cycles with a request pending: everything stays zero
      @(negedge PCLK);
      @(negedge PCLK);
      checkOutput("reset/psel", {28'd0, PSEL}, 32'd0);
      checkOutput("reset/penable", {31'd0, PENABLE}, 32'd0);
      checkOutput("reset/ready", {31'd0, READY_O}, 32'd0);
      checkOutput("reset/err", {31'd0, ERR_O}, 32'd0);
      checkOutput("reset/rdata", RDATA_O, 32'd0);
      checkOutput("reset/paddr", PADDR, 32'd0);
      checkOutput("reset/pwdata", PWDATA, 32'd0);
      checkOutput("reset/pwrite", {31'd0, PWRITE}, 32'd0);
      TRANSFER_I = 1'b0;
      PRESET     = 1'b0;
      @(negedge PCLK);

      // Write to slave 1 with one wait state: ready at T+4, a write returns no data
      runTransfer("write_s1", 32'h1000_1008, 1'b1, 32'h0000_0041, 1, 1, 1'b0, 4, 2, 32'd0, 1'b0);
      // Read from slave 2 with no wait states; slave 0's data must not leak through
      runTransfer("read_s2", 32'h1000_200C, 1'b0, 32'd0, 2, 0, 1'b0, 3, 1, 32'h0000_005A, 1'b0);
      // Slave 3 with five wait states while the other slaves hold PREADY high
      runTransfer("wait_s3", 32'h1000_3010, 1'b0, 32'd0, 3, 5, 1'b1, 8, 6, 32'h1234_5678, 1'b0);
      // Read from slave 0
      runTransfer("read_s0", 32'h1000_0004, 1'b0, 32'd0, 0, 0, 1'b0, 3, 1, 32'hFFFF_FFFF, 1'b0);
      // Address outside the window, then a slave index past NUM_SLAVES
      runTransfer("unmap_win", 32'h2000_0000, 1'b0, 32'd0, -1, 0, 1'b0, 1, 0, 32'd0, 1'b1);
      runTransfer("unmap_idx", 32'h1000_5000, 1'b1, 32'h0000_0077, -1, 0, 1'b0, 1, 0, 32'd0, 1'b1);
      // A good request right after an error completes normally
      runTransfer("after_err", 32'h1000_2000, 1'b0, 32'd0, 2, 0, 1'b0, 3, 1, 32'h0000_005A, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
      // Slave 3 never answers: abort after 16 ACCESS cycles, then a normal request
      runTransfer("timeout", 32'h1000_3000, 1'b0, 32'd0, 3, 1000, 1'b0, 18, 16, 32'd0, 1'b1);
      runTransfer("post_timeout", 32'h1000_2004, 1'b0, 32'd0, 2, 0, 1'b0, 3, 1, 32'h0000_005A, 1'b0);
`endif

      // Reset in the middle of an ACCESS phase: bus goes idle, no READY_O
      applyStimulus(32'h1000_3000, 1'b0, 32'd0);
      @(negedge PCLK);
      @(negedge PCLK);
      checkOutput("midreset/penable_before", {31'd0, PENABLE}, 32'd1);
      PRESET = 1'b1;
      @(negedge PCLK);
      checkOutput("midreset/psel", {28'd0, PSEL}, 32'd0);
      checkOutput("midreset/penable", {31'd0, PENABLE}, 32'd0);
      checkOutput("midreset/ready", {31'd0, READY_O}, 32'd0);
      TRANSFER_I = 1'b0;
      PRESET     = 1'b0;
      @(negedge PCLK);
      checkOutput("midreset/ready_after", {31'd0, READY_O}, 32'd0);
      @(negedge PCLK);

      // The bridge works normally again after the reset
      runTransfer("post_reset", 32'h1000_1000, 1'b1, 32'h0000_0099, 1, 0, 1'b0, 3, 1, 32'd0, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB3 requester that converts the RISC-V core's single-outstanding load/store requests into APB transfers toward the peripheral slaves (UART, GPIO, timer, ...).
- Decodes the address into one PSEL line per slave, sequences the SETUP/ACCESS phases, waits for the selected slave's PREADY, and returns read data with a one-cycle done pulse.
- Sits between the core data bus and all APB peripherals.

Parameters:
- NUM_SLAVES, 4, number of APB slaves and PSEL lines (1..16).
- BASE_ADDR, 32'h1000_0000, APB window base. Only ADDR_I[31:16] is compared.
- TIMEOUT_CYCLES, 16, ACCESS cycles without PREADY before abort. Used only with the optional feature.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-high reset
- TRANSFER_I  in  1  core request strobe
- ADDR_I  in  32  request byte address
- WRITE_I  in  1  1=write, 0=read
- WDATA_I  in  32  write data
- RDATA_O  out  32  read data, valid while READY_O=1
- READY_O  out  1  one-cycle completion pulse
- ERR_O  out  1  error flag, valid while READY_O=1
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB access phase
- PRDATA_ALL  in  32*NUM_SLAVES  slave k read data at bits [32k+31:32k]
- PREADY_ALL  in  NUM_SLAVES  slave k PREADY at bit k

Behaviour:
- Single clock domain: PCLK. Reset is synchronous and active-high: PRESET sampled on the PCLK rising edge.
- Reset values: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, RDATA_O=0, READY_O=0, ERR_O=0. All outputs are registered.
- Reset asserted mid-transfer: the bus returns to idle on the next edge and no READY_O is issued.
- Address decode:
  - Mapped when ADDR_I[31:16]==BASE_ADDR[31:16] and idx=ADDR_I[15:12] < NUM_SLAVES.
  - PSEL[idx] is the selected line. PADDR=ADDR_I, passed through unmodified.
- State machine: IDLE, SETUP, ACCESS, RESP.
  - IDLE: READY_O=0. If TRANSFER_I=1, latch ADDR_I, WRITE_I, WDATA_I and idx.
    - Mapped: go to SETUP.
    - Unmapped: go to RESP with err=1 and rdata=0. No APB activity.
    - TRANSFER_I is ignored in every other state; the core holds the request until READY_O.
  - SETUP: PSEL[idx]=1, PENABLE=0. PADDR, PWRITE, PWDATA are stable from here until exit from ACCESS. Go to ACCESS unconditionally.
  - ACCESS: PSEL[idx]=1, PENABLE=1.
    - Each cycle, sample PREADY_ALL[idx]; other slaves' PREADY bits are ignored.
    - PREADY=1: capture PRDATA_ALL slice idx into RDATA_O (reads only; writes give RDATA_O=0), err=0, go to RESP.
    - PREADY=0: stay in ACCESS.
  - RESP: PSEL=0, PENABLE=0, READY_O=1 for exactly this cycle, ERR_O=err. Go to IDLE.
- Latency: TRANSFER_I accepted at edge T. SETUP at T+1, ACCESS at T+2. With PREADY already high at T+2, READY_O=1 at T+3.
  - A slave with registered PREADY (one extra cycle) gives READY_O at T+4.
  - Unmapped access gives READY_O at T+1.
- Back-to-back: a new request is accepted at the earliest in the IDLE cycle after RESP. Minimum 4-cycle issue interval.
- PSEL is one-hot or all-zero at every cycle. PENABLE=1 only when PSEL!=0.
- PWDATA holds the latched value. PADDR and PWRITE hold the last transfer's values while idle.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments each ACCESS cycle without PREADY.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: go to RESP with ERR_O=1 and RDATA_O=0.
  - PREADY arriving in the same cycle the limit is reached wins: normal completion, ERR_O=0.
- Not defined: no counter. ACCESS waits indefinitely. ERR_O is set only for unmapped addresses.

Test Plan:
- Reset: PRESET=1 for 2 cycles with TRANSFER_I=1 → all outputs 0, no PSEL asserted.
- Write: ADDR_I=0x1000_1008, WDATA_I=0x0000_0041, slave 1 PREADY one cycle after PENABLE → PSEL=4'b0010; PADDR=0x1000_1008 and PWDATA=0x41 stable across SETUP/ACCESS; READY_O pulse at T+4, ERR_O=0.
- Read: ADDR_I=0x1000_200C, slave 2 drives PRDATA=0x0000_005A with PREADY at the first ACCESS cycle → READY_O at T+3, RDATA_O=0x5A; slave 0 PRDATA=0xFFFF_FFFF has no effect.
- Wait states: slave 3 holds PREADY=0 for 5 ACCESS cycles → PENABLE held 6 cycles; READY_O at T+8.
- Unmapped: ADDR_I=0x2000_0000, then ADDR_I=0x1000_5000 with NUM_SLAVES=4 → PSEL stays 0; READY_O=1 and ERR_O=1 at T+1.
- Timeout (macro defined, TIMEOUT_CYCLES=16): slave never asserts PREADY → abort after 16 ACCESS cycles; READY_O=1, ERR_O=1, RDATA_O=0; next request proceeds normally.
